pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- IW, 20, instruction width.
- OPW, 5, opcode width; opcode is ins_pm[IW-1:IW-OPW].
- JMP_PFX, 3'b111, jump class; matches when opcode[OPW-1:OPW-3] equals it.
- LD_OPC, 5'b10100, load opcode.
- HLT_OPC, 5'b10001, halt opcode.
- JUMP_STALL, 2, total stall cycles per jump; legal range 1..15.
- LOAD_STALL, 1, total stall cycles per load; legal range 1..15.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high.
- ins_pm, in, IW, instruction from program memory.
- ins_valid, in, 1, ins_pm is valid this cycle.
- resume, in, 1, release from halt.
- stall, out, 1, combinational stall request to the pipeline.
- stall_pm, out, 1, stall registered by one cycle, for program memory.
- stall_cause, out, 2, cause of stall: 00 none, 01 jump, 10 load, 11 halt.
- halted, out, 1, high while in HALT.
- stall_count, out, 16, count of stalled cycles.

Function
REQ-003 The state machine SHALL have states IDLE, JSTALL, LSTALL, HALT and RECOVER.
REQ-004 Decode SHALL occur only in IDLE with ins_valid=1; in every other state ins_pm SHALL be ignored.
REQ-005 When several decodes match, priority SHALL be halt > load > jump.
REQ-006 In IDLE, a decode match SHALL assert stall in the same cycle, with stall_cause set to the matching class.
REQ-007 On a jump match, next state SHALL be JSTALL with cnt=JUMP_STALL-2 if JUMP_STALL>1; otherwise next state SHALL be RECOVER.
REQ-008 On a load match, next state SHALL be LSTALL with cnt=LOAD_STALL-2 if LOAD_STALL>1; otherwise next state SHALL be RECOVER.
REQ-009 On a halt match, next state SHALL be HALT.
REQ-010 In JSTALL and LSTALL, stall SHALL be 1 and stall_cause SHALL hold the class; cnt SHALL decrement each cycle, and the state SHALL go to RECOVER when cnt=0. The total stall window therefore equals JUMP_STALL or LOAD_STALL cycles.
REQ-011 In HALT, stall SHALL be 1, stall_cause=11 and halted=1. On resume=1, next state SHALL be RECOVER; otherwise the state SHALL remain HALT indefinitely.
REQ-012 RECOVER SHALL last exactly one cycle, with stall=0, stall_cause=00 and no decode, and SHALL then go to IDLE. This prevents re-triggering on the still-held instruction.
REQ-013 In IDLE with no match, stall SHALL be 0 and stall_cause SHALL be 00.
REQ-014 stall_pm SHALL equal stall delayed by exactly one clock.
REQ-015 stall_count SHALL increment by 1 on every clock edge where stall=1 and reset=0, and SHALL saturate at 16'hFFFF.
REQ-016 resume SHALL be ignored outside HALT.
REQ-017 ins_valid=0 in IDLE SHALL produce no stall regardless of ins_pm.

Reset
REQ-018 With reset=1 at a clock edge, the following SHALL apply on the next cycle: state=IDLE, cnt=0, stall_pm=0, stall_count=0.
REQ-019 While reset=1, stall SHALL be forced to 0, stall_cause to 00 and halted to 0.
REQ-020 Reset SHALL take precedence over every other input and state, including reset mid-stall and in HALT.

Verification
REQ-021 Jump timing: defaults, ins_pm=20'hE0000, ins_valid=1 held → stall=1,1,0 on cycles 0,1,2; stall_pm=0,1,1,0 on cycles 0..3; stall_cause=01,01,00.
REQ-022 Load timing: ins_pm=20'hA0000 held → stall=1 for one cycle, then RECOVER (stall=0), then re-detect on cycle 2 since the instruction is still held. Separately, with LOAD_STALL=3 → three stall cycles, cause=10.
REQ-023 Halt: ins_pm=20'h88000, then resume low for 10 cycles → stall=1, halted=1 and cause=11 throughout. Pulse resume → stall=0 on the next cycle and one RECOVER cycle before IDLE.
REQ-024 Reset in JSTALL with JUMP_STALL=8 → next cycle stall=0, stall_pm=0, stall_count=0; the prior jump is not resumed.
REQ-025 Qualifiers: ins_valid=0 with ins_pm=20'hE0000 → no stall. Resume pulsed in IDLE → no effect.
REQ-026 Saturation: preload stall_count near 16'hFFFF via a long HALT (65535+ cycles) → holds at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall controller for jump, load and halt hazards
module pipe_stall_ctrl #(
  parameter int             IW         = 20,
  parameter int             OPW        = 5,
  parameter logic [2:0]     JMP_PFX    = 3'b111,
  parameter logic [OPW-1:0] LD_OPC     = 5'b10100,
  parameter logic [OPW-1:0] HLT_OPC    = 5'b10001,
  parameter int             JUMP_STALL = 2,
  parameter int             LOAD_STALL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] ins_pm,
  input  logic          ins_valid,
  input  logic          resume,
  output logic          stall,
  output logic          stall_pm,
  output logic [1:0]    stall_cause,
  output logic          halted,
  output logic [15:0]   stall_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_JSTALL  = 3'd1,
    S_LSTALL  = 3'd2,
    S_HALT    = 3'd3,
    S_RECOVER = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_JMP  = 2'b01;
  localparam logic [1:0] CAUSE_LD   = 2'b10;
  localparam logic [1:0] CAUSE_HLT  = 2'b11;

  // The decode cycle in IDLE is the first stall cycle, so the counter covers the rest.
  localparam logic [3:0] JCNT_INIT = 4'(JUMP_STALL - 2);
  localparam logic [3:0] LCNT_INIT = 4'(LOAD_STALL - 2);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           stall_pm_q;
  logic [15:0]    stall_count_q;

  logic [OPW-1:0] opcode;
  logic           dec_hlt, dec_ld, dec_jmp;
  logic           unused_ins;

  assign opcode     = ins_pm[IW-1:IW-OPW];
  assign unused_ins = ^ins_pm[IW-OPW-1:0];
  assign dec_hlt    = ins_valid && (opcode == HLT_OPC);
  assign dec_ld     = ins_valid && (opcode == LD_OPC);
  assign dec_jmp    = ins_valid && (opcode[OPW-1:OPW-3] == JMP_PFX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      stall_pm_q    <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_pm_q <= stall;
      if (stall && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dec_hlt) begin
          state_d = S_HALT;
        end else if (dec_ld) begin
          if (LOAD_STALL > 1) begin
            state_d = S_LSTALL;
            cnt_d   = LCNT_INIT;
          end else begin
            state_d = S_RECOVER;
          end
        end else if (dec_jmp) begin
          if (JUMP_STALL > 1) begin
            state_d = S_JSTALL;
            cnt_d   = JCNT_INIT;
          end else begin
            state_d = S_RECOVER;
          end
        end
      end
      S_JSTALL, S_LSTALL: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_RECOVER;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    stall_cause = CAUSE_NONE;
    halted      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (dec_hlt) begin
            stall       = 1'b1;
            stall_cause = CAUSE_HLT;
          end else if (dec_ld) begin
            stall       = 1'b1;
            stall_cause = CAUSE_LD;
          end else if (dec_jmp) begin
            stall       = 1'b1;
            stall_cause = CAUSE_JMP;
          end
        end
        S_JSTALL: begin
          stall       = 1'b1;
          stall_cause = CAUSE_JMP;
        end
        S_LSTALL: begin
          stall       = 1'b1;
          stall_cause = CAUSE_LD;
        end
        S_HALT: begin
          stall       = 1'b1;
          stall_cause = CAUSE_HLT;
          halted      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall_pm    = stall_pm_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed bench for pipe_stall_ctrl (default and long-stall instances)
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, reset1;
  logic [19:0] pm0, pm1;
  logic        v0, v1, r0, r1;
  logic        stall0, spm0, halted0;
  logic        stall1, spm1, halted1;
  logic [1:0]  cause0, cause1;
  logic [15:0] cnt0, cnt1;

  pipe_stall_ctrl u_dut0 (
    .clk(clk), .reset(reset0), .ins_pm(pm0), .ins_valid(v0), .resume(r0),
    .stall(stall0), .stall_pm(spm0), .stall_cause(cause0), .halted(halted0),
    .stall_count(cnt0)
  );

  pipe_stall_ctrl #(.JUMP_STALL(8), .LOAD_STALL(3)) u_dut1 (
    .clk(clk), .reset(reset1), .ins_pm(pm1), .ins_valid(v1), .resume(r1),
    .stall(stall1), .stall_pm(spm1), .stall_cause(cause1), .halted(halted1),
    .stall_count(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    v0 = 1'b1; pm0 = 20'h88000; r0 = 1'b0;
    v1 = 1'b1; pm1 = 20'hE0000; r1 = 1'b0;
    next_cycle();
    next_cycle();
    // Decodable instructions are present, so only the reset forcing keeps these low.
    sample();
    check_eq("rst_stall0", stall0, 0);
    check_eq("rst_halted0", halted0, 0);
    check_eq("rst_cause0", cause0, 0);
    check_eq("rst_stall1", stall1, 0);
    check_eq("rst_cnt0", cnt0, 0);
    check_eq("rst_spm0", spm0, 0);

    // Jump on default instance, held for two cycles
    next_cycle(); reset0 = 1'b0; reset1 = 1'b0; v1 = 1'b0; v0 = 1'b1; pm0 = 20'hE0000;
    sample();
    check_eq("j0_stall", stall0, 1); check_eq("j0_spm", spm0, 0); check_eq("j0_cause", cause0, 1);
    next_cycle(); sample();
    check_eq("j1_stall", stall0, 1); check_eq("j1_spm", spm0, 1); check_eq("j1_cause", cause0, 1);
    next_cycle(); sample();
    check_eq("j2_stall", stall0, 0); check_eq("j2_spm", spm0, 1); check_eq("j2_cause", cause0, 0);
    next_cycle(); v0 = 1'b0; sample();
    check_eq("j3_spm", spm0, 0);
    check_eq("inv_stall", stall0, 0);
    check_eq("j3_cnt", cnt0, 2);

    // Resume in IDLE has no effect; a following jump still decodes normally
    next_cycle(); r0 = 1'b1; sample();
    check_eq("res_idle_stall", stall0, 0); check_eq("res_idle_halted", halted0, 0);
    next_cycle(); r0 = 1'b0; v0 = 1'b1; pm0 = 20'hE0000; sample();
    check_eq("res_j0_stall", stall0, 1); check_eq("res_j0_cause", cause0, 1);
    next_cycle(); v0 = 1'b0; sample();
    check_eq("res_j1_stall", stall0, 1);
    next_cycle(); sample();
    check_eq("res_j2_stall", stall0, 0);
    check_eq("res_j2_cnt", cnt0, 4);

    // Load with one-cycle stall, held so it re-detects after RECOVER
    next_cycle(); v0 = 1'b1; pm0 = 20'hA0000; sample();
    check_eq("l0_stall", stall0, 1); check_eq("l0_cause", cause0, 2);
    next_cycle(); sample();
    check_eq("l1_stall", stall0, 0); check_eq("l1_cause", cause0, 0); check_eq("l1_spm", spm0, 1);
    next_cycle(); sample();
    check_eq("l2_stall", stall0, 1); check_eq("l2_cause", cause0, 2); check_eq("l2_spm", spm0, 0);
    next_cycle(); v0 = 1'b0; sample();
    check_eq("l3_stall", stall0, 0);
    check_eq("l3_cnt", cnt0, 6);

    // Halt, ten idle cycles, then a resume pulse
    next_cycle(); v0 = 1'b1; pm0 = 20'h88000; sample();
    check_eq("h0_stall", stall0, 1); check_eq("h0_cause", cause0, 3); check_eq("h0_halted", halted0, 0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); sample();
      check_eq($sformatf("h%0d_stall", i), stall0, 1);
      check_eq($sformatf("h%0d_halted", i), halted0, 1);
      check_eq($sformatf("h%0d_cause", i), cause0, 3);
    end
    next_cycle(); r0 = 1'b1; sample();
    check_eq("h11_stall", stall0, 1); check_eq("h11_halted", halted0, 1);
    next_cycle(); r0 = 1'b0; sample();
    check_eq("hrec_stall", stall0, 0); check_eq("hrec_halted", halted0, 0);
    check_eq("hrec_cause", cause0, 0); check_eq("hrec_spm", spm0, 1);
    next_cycle(); sample();
    check_eq("hre_stall", stall0, 1); check_eq("hre_cause", cause0, 3);
    check_eq("hre_cnt", cnt0, 18);

    // Stay halted long enough to saturate the counter
    repeat (65600) next_cycle();
    sample();
    check_eq("sat_cnt", cnt0, 16'hFFFF); check_eq("sat_halted", halted0, 1);
    next_cycle(); sample();
    check_eq("sat_hold", cnt0, 16'hFFFF);

    // Reset while halted
    next_cycle(); reset0 = 1'b1; sample();
    check_eq("hrst_stall", stall0, 0); check_eq("hrst_halted", halted0, 0); check_eq("hrst_cause", cause0, 0);
    next_cycle(); reset0 = 1'b0; v0 = 1'b0; sample();
    check_eq("hrst_cnt", cnt0, 0); check_eq("hrst_spm", spm0, 0);
    check_eq("hrst_stall2", stall0, 0); check_eq("hrst_halted2", halted0, 0);

    // LOAD_STALL=3: ins_pm dropped after decode must not shorten the window
    next_cycle(); v1 = 1'b1; pm1 = 20'hA0000; sample();
    check_eq("l3s0_stall", stall1, 1); check_eq("l3s0_cause", cause1, 2);
    next_cycle(); v1 = 1'b0; sample();
    check_eq("l3s1_stall", stall1, 1); check_eq("l3s1_cause", cause1, 2);
    next_cycle(); sample();
    check_eq("l3s2_stall", stall1, 1); check_eq("l3s2_cause", cause1, 2);
    next_cycle(); sample();
    check_eq("l3s3_stall", stall1, 0); check_eq("l3s3_cause", cause1, 0);
    check_eq("l3s3_cnt", cnt1, 3);

    // JUMP_STALL=8: reset in JSTALL abandons the jump
    next_cycle(); v1 = 1'b1; pm1 = 20'hE0000; sample();
    check_eq("j8_0_stall", stall1, 1); check_eq("j8_0_cause", cause1, 1);
    next_cycle(); v1 = 1'b0; sample();
    check_eq("j8_1_stall", stall1, 1);
    next_cycle(); sample();
    check_eq("j8_2_stall", stall1, 1); check_eq("j8_2_cause", cause1, 1);
    next_cycle(); reset1 = 1'b1; sample();
    check_eq("j8_rst_stall", stall1, 0); check_eq("j8_rst_cause", cause1, 0);
    next_cycle(); reset1 = 1'b0; sample();
    check_eq("j8_post_stall", stall1, 0); check_eq("j8_post_spm", spm1, 0);
    check_eq("j8_post_cnt", cnt1, 0);
    next_cycle(); sample();
    check_eq("j8_post2_stall", stall1, 0); check_eq("j8_post2_cause", cause1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
